// File: rtl/fir_stream_ctrl.sv
// fir_stream_ctrl: streaming sequencer around the combinational 6-tap fir datapath.
// Accepts samples on a valid/ready input, keeps the tap delay line, waits one
// cycle for the datapath to settle, rescales the Q12 sum and presents it on a
// valid/ready output.
// Optional build macro FIR_PRIME_EN: suppress outputs until the delay line is full.
module fir_stream_ctrl #(
  parameter int DATA_W = 32,
  parameter int NTAPS  = 6,   // must match the datapath tap count (six tap ports)
  parameter int QSHIFT = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              flush,
  output logic [DATA_W-1:0] tap_0,
  output logic [DATA_W-1:0] tap_1,
  output logic [DATA_W-1:0] tap_2,
  output logic [DATA_W-1:0] tap_3,
  output logic [DATA_W-1:0] tap_4,
  output logic [DATA_W-1:0] tap_5,
  input  logic [DATA_W-1:0] fir_result,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
);

  localparam int CNT_W = $clog2(NTAPS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [DATA_W-1:0] taps [NTAPS];
  logic [CNT_W-1:0]  fill_cnt;
  logic              accept;
  logic              flush_now;
  logic              capture;
  logic [DATA_W-1:0] result_scaled;

  // Handshake and flush qualifiers; flush only acts while waiting for a sample.
  assign flush_now = (state == IDLE) && flush;
  assign accept    = s_valid && s_ready;

  // Arithmetic shift keeps the sign and rounds toward minus infinity.
  assign result_scaled = DATA_W'($signed(fir_result) >>> QSHIFT);

`ifdef FIR_PRIME_EN
  // fill_cnt already includes the sample taken on entry to EVAL.
  assign capture = (fill_cnt == CNT_W'(NTAPS));
`else
  assign capture = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE -> EVAL on accept, EVAL -> HOLD (or IDLE while priming),
  // HOLD -> IDLE once downstream takes the result.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = EVAL;
      EVAL: state_next = capture ? HOLD : IDLE;
      HOLD: if (m_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs: input side is open only in IDLE without a flush.
  always_comb begin
    s_ready = 1'b0;
    if ((state == IDLE) && !flush) begin
      s_ready = 1'b1;
    end
  end

  // Delay line: cleared by flush, shifted by one on each accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) begin
        taps[i] <= '0;
      end
    end else if (flush_now) begin
      for (int i = 0; i < NTAPS; i++) begin
        taps[i] <= '0;
      end
    end else if (accept) begin
      taps[0] <= s_data;
      for (int i = 1; i < NTAPS; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  // Fill count of valid history samples, saturating at the tap count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt <= '0;
    end else if (flush_now) begin
      fill_cnt <= '0;
    end else if (accept && (fill_cnt != CNT_W'(NTAPS))) begin
      fill_cnt <= fill_cnt + 1'b1;
    end
  end

  // Output register: capture the settled datapath result in EVAL, hold until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if ((state == EVAL) && capture) begin
      m_valid <= 1'b1;
      m_data  <= result_scaled;
    end else if ((state == HOLD) && m_ready) begin
      m_valid <= 1'b0;
    end
  end

  assign tap_0 = taps[0];
  assign tap_1 = taps[1];
  assign tap_2 = taps[2];
  assign tap_3 = taps[3];
  assign tap_4 = taps[4];
  assign tap_5 = taps[5];

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Testbench for fir_stream_ctrl: models the fir datapath, drives directed and
// random sample streams, and checks outputs through a scoreboard queue.
module tb_fir_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        flush = 1'b0;
  logic [31:0] tap_0, tap_1, tap_2, tap_3, tap_4, tap_5;
  logic [31:0] fir_result;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;

`ifdef FIR_PRIME_EN
  localparam int PRE = 5;
  localparam bit PRIME = 1'b1;
`else
  localparam int PRE = 0;
  localparam bit PRIME = 1'b0;
`endif

  int coef [6] = '{-276, 1163, 1819, 1819, 1163, -276};

  int hist [6];
  int fill;
  int sb_q [$];
  int pass_cnt = 0;
  int total_cnt = 0;
  int xfer_cnt = 0;
  bit rand_ready = 1'b0;

  fir_stream_ctrl #(.DATA_W(32), .NTAPS(6), .QSHIFT(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .flush(flush),
    .tap_0(tap_0), .tap_1(tap_1), .tap_2(tap_2),
    .tap_3(tap_3), .tap_4(tap_4), .tap_5(tap_5),
    .fir_result(fir_result),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );

  always #5 clk = ~clk;

  // Combinational fir datapath stand-in driven from the DUT taps.
  always_comb begin
    fir_result = 32'(int'($signed(tap_0)) * coef[0] + int'($signed(tap_1)) * coef[1] +
                     int'($signed(tap_2)) * coef[2] + int'($signed(tap_3)) * coef[3] +
                     int'($signed(tap_4)) * coef[4] + int'($signed(tap_5)) * coef[5]);
  end

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d required %0d", name, act, exp);
  endtask

  // Reference model: sample history as a plain array, y = sum(c*x) >>> 12.
  function automatic void model_clear();
    for (int i = 0; i < 6; i++) hist[i] = 0;
    fill = 0;
  endfunction

  function automatic void model_accept(input int x);
    int acc;
    for (int i = 5; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
    if (fill < 6) fill++;
    acc = 0;
    for (int i = 0; i < 6; i++) acc += coef[i] * hist[i];
    if (!PRIME || fill == 6) sb_q.push_back(acc >>> 12);
  endfunction

  // Monitor: every completed output transfer is popped and compared.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      xfer_cnt++;
      if (sb_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_output: got %0d required none", $signed(m_data));
      end else begin
        check("m_data", int'($signed(m_data)), sb_q.pop_front());
      end
    end
  end

  // Random downstream readiness during the random phase.
  always @(posedge clk) begin
    if (rand_ready) begin
      #1 m_ready = 1'($urandom % 2);
    end
  end

  task automatic send(input int x);
    int n;
    @(posedge clk); #1;
    s_data = 32'(x);
    s_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 200) begin n++; @(negedge clk); end
    if (!s_ready) begin
      check("send_timeout", 0, 1);
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(x);
    #1 s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(sb_q.size() == 0 && s_ready && !m_valid) && n < 300) begin n++; @(negedge clk); end
    if (n >= 300) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_mvalid();
    int n;
    n = 0;
    @(negedge clk);
    while (!m_valid && n < 50) begin n++; @(negedge clk); end
    if (!m_valid) check("mvalid_timeout", 0, 1);
  endtask

  task automatic do_flush();
    wait_idle();
    @(posedge clk); #1;
    flush = 1'b1;
    s_valid = 1'b1;
    s_data = 32'd777;
    @(negedge clk);
    check("flush_s_ready", int'(s_ready), 0);
    @(posedge clk); #1;
    flush = 1'b0;
    s_valid = 1'b0;
    check("flush_taps", int'(tap_0 | tap_1 | tap_2 | tap_3 | tap_4 | tap_5), 0);
    model_clear();
  endtask

  initial begin
    int exp_hold;
    int x0;
    model_clear();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_taps", int'(tap_0 | tap_1 | tap_2 | tap_3 | tap_4 | tap_5), 0);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_m_data", int'(m_data), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_s_ready", int'(s_ready), 1);

    // Impulse response
    m_ready = 1'b1;
    send(4096);
    repeat (6) send(0);
    wait_idle();

    // DC response
    do_flush();
    repeat (8) send(4096);
    wait_idle();

    // Flush after partial fill, then a single sample from clean history
    repeat (3) send(4096);
    do_flush();
    send(4096);
    wait_idle();

    // Backpressure held for 10 cycles in HOLD
    do_flush();
    repeat (PRE) send(0);
    wait_idle();
    m_ready = 1'b0;
    send(4096);
    wait_mvalid();
    exp_hold = (sb_q.size() > 0) ? sb_q[0] : 32'h7fff_ffff;
    x0 = xfer_cnt;
    repeat (10) begin
      @(negedge clk);
      check("bp_m_valid", int'(m_valid), 1);
      check("bp_m_data", int'($signed(m_data)), exp_hold);
      check("bp_s_ready", int'(s_ready), 0);
    end
    @(posedge clk); #1 m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_one_xfer", xfer_cnt - x0, 1);
    check("bp_s_ready_after", int'(s_ready), 1);
    check("bp_m_valid_after", int'(m_valid), 0);

    // Asynchronous reset while holding an output
    do_flush();
    repeat (PRE) send(0);
    wait_idle();
    m_ready = 1'b0;
    send(4096);
    wait_mvalid();
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("arst_m_valid", int'(m_valid), 0);
    check("arst_tap_0", int'(tap_0), 0);
    sb_q.delete();
    model_clear();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("arst_s_ready", int'(s_ready), 1);
    m_ready = 1'b1;
    repeat (PRE) send(0);
    send(4096);
    wait_idle();

    // Random stream with random backpressure and occasional flushes
    rand_ready = 1'b1;
    repeat (150) begin
      if ($urandom % 20 == 0) do_flush();
      else send(int'($urandom_range(0, 40000)) - 20000);
    end
    rand_ready = 1'b0;
    @(posedge clk); #2 m_ready = 1'b1;
    wait_idle();
    check("scoreboard_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
